// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: ID/EX status from the pipeline and the stall/flush controls back to it.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_redirect;
    logic       ex_md_start;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt, ex_redirect, ex_md_start,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
               md_busy, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt, ex_redirect, ex_md_start,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
               md_busy, md_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / mul-div hazard control; outputs combinational, zero latency.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles and flush_events counters.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] CNT_INIT = (MD_LATENCY > 2) ? 5'(MD_LATENCY - 3) : 5'd0;

    md_state_e  state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       md_stall;
    logic       lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (hz.ex_md_start) begin
                    if (MD_LATENCY > 2) begin
                        state_d = MD_BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = MD_DONE;
                    end
                end
            end
            MD_BUSY: begin
                if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                else               state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        // A redirect squashes the op in EX, so any mul/div in flight is abandoned.
        if (hz.ex_redirect) begin
            state_d = MD_IDLE;
            cnt_d   = 5'd0;
        end
    end

    assign md_stall = ((state_q == MD_IDLE) && hz.ex_md_start) || (state_q == MD_BUSY);
    assign lu = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                 (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

    always_comb begin
        hz.pc_stall     = 1'b0;
        hz.if_id_stall  = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_stall  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        // Outputs are forced low for the whole reset assertion, not just after the edge.
        if (rst_n) begin
            if (hz.ex_redirect) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (md_stall) begin
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_stall  = 1'b1;
                hz.ex_mem_flush = 1'b1;
            end else if (lu) begin
                hz.pc_stall    = 1'b1;
                hz.if_id_stall = 1'b1;
                hz.id_ex_flush = 1'b1;
            end
        end
    end

    assign hz.md_busy = rst_n && (state_q != MD_IDLE);
    assign hz.md_done = rst_n && (state_q == MD_DONE);

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (hz.pc_stall)    stall_cycles <= stall_cycles + 32'd1;
            if (hz.if_id_flush) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: MD_LATENCY=4 and MD_LATENCY=2 instances share stimulus, checked
// against a cycle-index reference model plus directed scenarios.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_memread, ex_redirect, ex_md_start;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if ifc ();
    hazard_ctrl_if if2 ();

    assign ifc.id_rs = id_rs;             assign if2.id_rs = id_rs;
    assign ifc.id_rt = id_rt;             assign if2.id_rt = id_rt;
    assign ifc.id_uses_rs = id_uses_rs;   assign if2.id_uses_rs = id_uses_rs;
    assign ifc.id_uses_rt = id_uses_rt;   assign if2.id_uses_rt = id_uses_rt;
    assign ifc.ex_memread = ex_memread;   assign if2.ex_memread = ex_memread;
    assign ifc.ex_rt = ex_rt;             assign if2.ex_rt = ex_rt;
    assign ifc.ex_redirect = ex_redirect; assign if2.ex_redirect = ex_redirect;
    assign ifc.ex_md_start = ex_md_start; assign if2.ex_md_start = ex_md_start;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc4, fe4, sc2, fe2;
    hazard_ctrl #(.MD_LATENCY(4)) dut  (.clk(clk), .rst_n(rst_n), .hz(ifc),
                                        .stall_cycles(sc4), .flush_events(fe4));
    hazard_ctrl #(.MD_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .hz(if2),
                                        .stall_cycles(sc2), .flush_events(fe2));
`else
    hazard_ctrl #(.MD_LATENCY(4)) dut  (.clk(clk), .rst_n(rst_n), .hz(ifc));
    hazard_ctrl #(.MD_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .hz(if2));
`endif

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, md_busy, md_done}
    wire [7:0] o4 = {ifc.pc_stall, ifc.if_id_stall, ifc.if_id_flush, ifc.id_ex_stall,
                     ifc.id_ex_flush, ifc.ex_mem_flush, ifc.md_busy, ifc.md_done};
    wire [7:0] o2 = {if2.pc_stall, if2.if_id_stall, if2.if_id_flush, if2.id_ex_stall,
                     if2.id_ex_flush, if2.ex_mem_flush, if2.md_busy, if2.md_done};

    // Reference model: m = cycles the current mul/div op has already spent in EX (0 = none).
    int          m4, m2;
    int unsigned pc_cnt4, fl_cnt4, pc_cnt2, fl_cnt2;

    function automatic logic [7:0] exp_out(input int m, input int lat);
        logic [7:0] e;
        bit active, stall, lu;
        int k;
        e = 8'h00;
        if (rst_n !== 1'b1) return e;
        active = (m > 0) || ex_md_start;
        k      = m + 1;
        stall  = active && (k <= lat - 1);
        lu = ex_memread && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        e[1] = (m > 0);
        e[0] = (m > 0) && (k == lat);
        if (ex_redirect)  begin e[5] = 1; e[3] = 1; end
        else if (stall)   begin e[7] = 1; e[6] = 1; e[4] = 1; e[2] = 1; end
        else if (lu)      begin e[7] = 1; e[6] = 1; e[3] = 1; end
        return e;
    endfunction

    function automatic int nxt(input int m, input int lat);
        bit active;
        if (ex_redirect) return 0;
        active = (m > 0) || ex_md_start;
        if (!active) return 0;
        return (m + 1 == lat) ? 0 : m + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= 0; m2 <= 0;
            pc_cnt4 <= 0; fl_cnt4 <= 0; pc_cnt2 <= 0; fl_cnt2 <= 0;
        end else begin
            m4 <= nxt(m4, 4);
            m2 <= nxt(m2, 2);
            pc_cnt4 <= pc_cnt4 + 32'(exp_out(m4, 4)[7]);
            fl_cnt4 <= fl_cnt4 + 32'(exp_out(m4, 4)[5]);
            pc_cnt2 <= pc_cnt2 + 32'(exp_out(m2, 2)[7]);
            fl_cnt2 <= fl_cnt2 + 32'(exp_out(m2, 2)[5]);
        end
    end

    task automatic clear_in();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_memread = 0; ex_rt = 0; ex_redirect = 0; ex_md_start = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_in();
        end
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        ex_md_start = 1; ex_memread = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
        #3;
        n_tests++;
        if (o4 !== 8'h00 || o2 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got %b/%b expected 00000000", o4, o2);
        end
        @(negedge clk);
        clear_in();
        rst_n = 1;
        #1;
        n_tests++;
        if (o4 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release got %b expected 00000000", o4);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_in();
        ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
        #1;
        n_tests++;
        if (o4 !== 8'b1100_1000) begin
            n_fail++;
            $display("FAIL lu_rs got %b expected 11001000", o4);
        end
        @(negedge clk);
        id_rs = 3; id_rt = 8; id_uses_rt = 1; id_uses_rs = 1;
        #1;
        n_tests++;
        if (o4 !== 8'b1100_1000) begin
            n_fail++;
            $display("FAIL lu_rt got %b expected 11001000", o4);
        end
        @(negedge clk);
        id_uses_rt = 0;
        #1;
        n_tests++;
        if (o4 !== 8'h00) begin
            n_fail++;
            $display("FAIL lu_unused_src got %b expected 00000000", o4);
        end
        @(negedge clk);
        ex_rt = 0; id_rs = 0; id_uses_rs = 1;
        #1;
        n_tests++;
        if (o4 !== 8'h00) begin
            n_fail++;
            $display("FAIL lu_r0 got %b expected 00000000", o4);
        end
    endtask

    task automatic test_muldiv();
        logic [7:0] e4 [5];
        logic [7:0] e2 [5];
        e4 = '{8'b1101_0100, 8'b1101_0110, 8'b1101_0110, 8'b0000_0011, 8'b1101_0100};
        e2 = '{8'b1101_0100, 8'b0000_0011, 8'b1101_0100, 8'b0000_0011, 8'b1101_0100};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_in();
            ex_md_start = 1;
            #1;
            n_tests++;
            if (o4 !== e4[c]) begin
                n_fail++;
                $display("FAIL md_lat4 cyc%0d got %b expected %b", c + 1, o4, e4[c]);
            end
            n_tests++;
            if (o2 !== e2[c]) begin
                n_fail++;
                $display("FAIL md_lat2 cyc%0d got %b expected %b", c + 1, o2, e2[c]);
            end
        end
        idle_cycles(5);
    endtask

    task automatic test_redirect();
        @(negedge clk);
        clear_in();
        ex_memread = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1; ex_redirect = 1;
        #1;
        n_tests++;
        if (o4 !== 8'b0010_1000) begin
            n_fail++;
            $display("FAIL redirect_lu got %b expected 00101000", o4);
        end
        @(negedge clk);
        clear_in();
        ex_md_start = 1;
        @(negedge clk);
        ex_redirect = 1;
        #1;
        n_tests++;
        if (o4 !== 8'b0010_1010) begin
            n_fail++;
            $display("FAIL redirect_busy got %b expected 00101010", o4);
        end
        @(negedge clk);
        clear_in();
        #1;
        n_tests++;
        if (o4 !== 8'h00) begin
            n_fail++;
            $display("FAIL redirect_abort got %b expected 00000000", o4);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        clear_in();
        ex_md_start = 1;
        @(negedge clk);
        #1;
        n_tests++;
        if (o4 !== 8'b1101_0110) begin
            n_fail++;
            $display("FAIL pre_reset_busy got %b expected 11010110", o4);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if (o4 !== 8'h00 || o2 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_busy got %b/%b expected 00000000", o4, o2);
        end
        @(negedge clk);
        clear_in();
        rst_n = 1;
        #1;
        n_tests++;
        if (o4 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_busy_release got %b expected 00000000", o4);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        clear_in();
        rst_n = 0;
        #1;
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_in();
            ex_md_start = 1;
        end
        @(negedge clk);
        clear_in();
        ex_memread = 1; ex_rt = 4; id_rs = 4; id_uses_rs = 1;
        @(negedge clk);
        clear_in();
        ex_redirect = 1;
        @(negedge clk);
        clear_in();
        #1;
        n_tests++;
        if (sc4 !== 32'd4 || fe4 !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_counts got %0d/%0d expected 4/1", sc4, fe4);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] e4, e2;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            id_uses_rs  = 1'($urandom_range(0, 1));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_memread  = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 9) == 0);
            ex_md_start = ($urandom_range(0, 3) != 0);
            #1;
            e4 = exp_out(m4, 4);
            e2 = exp_out(m2, 2);
            n_tests++;
            if (o4 !== e4) begin
                n_fail++;
                $display("FAIL rand_lat4 cyc%0d got %b expected %b", c, o4, e4);
            end
            n_tests++;
            if (o2 !== e2) begin
                n_fail++;
                $display("FAIL rand_lat2 cyc%0d got %b expected %b", c, o2, e2);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_tests++;
            if (sc4 !== pc_cnt4 || fe4 !== fl_cnt4 || sc2 !== pc_cnt2 || fe2 !== fl_cnt2) begin
                n_fail++;
                $display("FAIL rand_perf cyc%0d got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d",
                         c, sc4, fe4, sc2, fe2, pc_cnt4, fl_cnt4, pc_cnt2, fl_cnt2);
            end
`endif
        end
        idle_cycles(5);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_redirect();
        test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
